axi_stream_rr_arbiter: RTL and testbench
========================================

Name: axi_stream_rr_arbiter

Overview:
- Packet-granular round-robin arbiter: shares one AXI-Stream master output among num_inputs AXI-Stream slave inputs.
- A grant is held from the first beat of a packet until its TLAST beat is transferred, so packets are never interleaved.
- Source index of each beat is reported on m_tid.
- Sits between per-channel stream producers and a single shared stream consumer (DMA or serializer).

Parameters:
- num_inputs, 4, number of slave inputs; legal range 2..16.
- byte_width, 4, TDATA width in bytes.
- user_width, 1, TUSER width; must be at least 1.
- idx_width, $clog2(num_inputs), derived localparam; width of grant index and m_tid.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_tvalid  in  num_inputs  per-input TVALID.
- s_tready  out  num_inputs  per-input TREADY.
- s_tdata  in  num_inputs*8*byte_width  flattened TDATA; input i occupies slice i.
- s_tkeep  in  num_inputs*byte_width  flattened TKEEP.
- s_tlast  in  num_inputs  per-input TLAST.
- s_tuser  in  num_inputs*user_width  flattened TUSER.
- m_tvalid  out  1  output TVALID.
- m_tready  in  1  output TREADY.
- m_tdata  out  8*byte_width  output TDATA.
- m_tkeep  out  byte_width  output TKEEP.
- m_tlast  out  1  output TLAST.
- m_tuser  out  user_width  output TUSER.
- m_tid  out  idx_width  index of the granted input.
- busy  out  1  high while in the GRANTED state.
- grant_idx  out  idx_width  current or most recent grant, from the last_grant register.

Behaviour:
- State registers: state (IDLE, GRANTED), grant (idx_width), last_grant (idx_width).
- Reset (resetn low, asynchronous):
  - state=IDLE, grant=0, last_grant=num_inputs-1, so input 0 has top priority after reset.
  - While in reset: m_tvalid=0, s_tready=all 0, busy=0.
- IDLE:
  - m_tvalid=0, s_tready=all 0.
  - If any s_tvalid bit is high, select the first requester searching upward from last_grant+1, wrapping modulo num_inputs.
  - On the next edge: grant=selected, last_grant=selected, state=GRANTED.
  - If no bit is high, remain in IDLE.
- GRANTED (combinational mux on the registered grant):
  - m_tvalid=s_tvalid[grant]; m_tdata, m_tkeep, m_tlast and m_tuser come from slice grant; m_tid=grant.
  - s_tready[grant]=m_tready; all other s_tready bits are 0.
  - The mux select never changes mid-packet, so the output honours the TVALID-hold and payload-stability rules whenever the granted input does.
- Release:
  - When m_tvalid && m_tready && m_tlast, the next state is IDLE.
  - Arbitration latency is 1 cycle: at least one IDLE cycle separates consecutive packets.
- Non-granted inputs may raise or hold TVALID indefinitely. They see TREADY=0, which is legal stalling.
- Granted input drops TVALID mid-packet (protocol violation upstream): the arbiter stays in GRANTED, m_tvalid follows the input, and no timeout applies.
- Reset mid-packet: the grant is dropped immediately and the partial packet is truncated. After reset release, arbitration restarts with input 0 highest priority.
- Single-beat packet (TLAST on the first beat): grant lasts exactly one handshake cycle.
- Combinational paths from m_tready to s_tready and from s_tvalid to m_tvalid are permitted.

Test Plan:
- num_inputs=4; inputs 0..3 each hold a 2-beat packet valid after reset, with m_tready=1 -> m_tid order 0,0,1,1,2,2,3,3; one m_tvalid=0 cycle between packets; s_tready high only on the granted index.
- Only input 2 requests, with a 3-beat packet, right after reset -> grant=2 within 1 cycle; m_tdata matches the three beats; then IDLE with busy=0.
- Grant on input 1 with a 4-beat packet while input 0 requests continuously -> no input 0 beat appears until after input 1's TLAST. The next grant goes to input 2 if it is requesting, otherwise wraps to input 0.
- Granted input valid with m_tready low for 5 cycles mid-packet -> m_tvalid, m_tdata, m_tlast and m_tid are stable for those 5 cycles; s_tready is all 0.
- resetn pulsed low for 1 cycle during beat 2 of a 4-beat packet from input 3 -> m_tvalid=0 and s_tready=0 immediately (asynchronous); after release, input 0 wins if requesting.
- A single-beat packet on each of inputs 0 and 1 -> each is granted for exactly one cycle; busy=1 for one cycle per packet.

Source files
------------

// File: rtl/axi_stream_rr_arbiter.sv
// Purpose: packet-granular round-robin arbiter sharing one AXI-Stream master among num_inputs slaves.
// Latency: 1 idle arbitration cycle before each packet, then a combinational pass-through of the granted input.
// Backpressure: m_tready is routed combinationally to s_tready of the granted input only; others see 0.
//
// Ports:
//   clk, resetn            single clock, asynchronous active-low reset
//   s_tvalid/s_tready/...  flattened slave inputs; input i occupies slice i of each bus
//   m_tvalid/m_tready/...  shared master output; m_tid carries the granted input index
//   busy                   high while a packet grant is held
//   grant_idx              current or most recent grant (the round-robin pointer)
module axi_stream_rr_arbiter #(
    parameter int  num_inputs = 4,
    parameter int  byte_width = 4,
    parameter int  user_width = 1,
    localparam int idx_width  = $clog2(num_inputs)
) (
    input  logic                                 clk,
    input  logic                                 resetn,

    input  logic [num_inputs-1:0]                s_tvalid,
    output logic [num_inputs-1:0]                s_tready,
    input  logic [num_inputs*8*byte_width-1:0]   s_tdata,
    input  logic [num_inputs*byte_width-1:0]     s_tkeep,
    input  logic [num_inputs-1:0]                s_tlast,
    input  logic [num_inputs*user_width-1:0]     s_tuser,

    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic [8*byte_width-1:0]              m_tdata,
    output logic [byte_width-1:0]                m_tkeep,
    output logic                                 m_tlast,
    output logic [user_width-1:0]                m_tuser,
    output logic [idx_width-1:0]                 m_tid,

    output logic                                 busy,
    output logic [idx_width-1:0]                 grant_idx
);

    localparam int data_width = 8 * byte_width;

    // Elaboration-time guard on the supported configuration range.
    if (num_inputs < 2 || num_inputs > 16) begin : g_bad_num_inputs
        $error("axi_stream_rr_arbiter: num_inputs must be within 2..16");
    end
    if (user_width < 1) begin : g_bad_user_width
        $error("axi_stream_rr_arbiter: user_width must be at least 1");
    end

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [idx_width-1:0]   grant_q;
    logic [idx_width-1:0]   grant_d;
    logic [idx_width-1:0]   last_grant_q;
    logic [idx_width-1:0]   last_grant_d;

    // ------------------------------------------------------------------
    // Unpack the flattened slave payload buses so the output mux is a
    // plain array index on the registered grant.
    // ------------------------------------------------------------------
    logic [data_width-1:0]  data_arr [num_inputs];
    logic [byte_width-1:0]  keep_arr [num_inputs];
    logic [user_width-1:0]  user_arr [num_inputs];

    for (genvar gi = 0; gi < num_inputs; gi++) begin : g_unpack
        assign data_arr[gi] = s_tdata[gi*data_width +: data_width];
        assign keep_arr[gi] = s_tkeep[gi*byte_width +: byte_width];
        assign user_arr[gi] = s_tuser[gi*user_width +: user_width];
    end

    // Payload follows grant_q, which only changes between packets, so the
    // output payload is as stable as the granted input's payload.
    assign m_tdata   = data_arr[grant_q];
    assign m_tkeep   = keep_arr[grant_q];
    assign m_tuser   = user_arr[grant_q];
    assign m_tlast   = s_tlast[grant_q];
    assign m_tid     = grant_q;
    assign grant_idx = last_grant_q;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester strictly after last_grant_q,
    // wrapping, so last_grant_q itself is considered last.
    // ------------------------------------------------------------------
    logic                   sel_vld;
    logic [idx_width-1:0]   sel_idx;
    int unsigned            cand;

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = 0;
        for (int k = 1; k <= num_inputs; k++) begin
            cand = (32'(last_grant_q) + 32'(k)) % 32'(num_inputs);
            if (!sel_vld && s_tvalid[idx_width'(cand)]) begin
                sel_vld = 1'b1;
                sel_idx = idx_width'(cand);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_tvalid     = 1'b0;
        s_tready     = '0;
        busy         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_vld) begin
                    grant_d      = sel_idx;
                    last_grant_d = sel_idx;
                    state_d      = ST_GRANTED;
                end
            end

            ST_GRANTED: begin
                busy              = 1'b1;
                m_tvalid          = s_tvalid[grant_q];
                s_tready[grant_q] = m_tready;
                // Grant is held until the TLAST beat actually transfers; a
                // granted input that drops TVALID mid-packet keeps the grant.
                if (m_tvalid && m_tready && m_tlast) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset leaves last_grant at the top index so input 0 wins first.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= idx_width'(num_inputs - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_axi_stream_rr_arbiter.sv
// Purpose: self-checking bench for axi_stream_rr_arbiter (4 inputs, 32-bit data).
// Latency: sources are driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: m_tready is driven by the bench; sources advance only on their own handshake.
module tb_axi_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int BW = 4;
    localparam int UW = 1;
    localparam int IW = 2;
    localparam int DW = 8 * BW;

    logic              clk = 1'b0;
    logic              resetn;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tready;
    logic [N*DW-1:0]   s_tdata;
    logic [N*BW-1:0]   s_tkeep;
    logic [N-1:0]      s_tlast;
    logic [N*UW-1:0]   s_tuser;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [BW-1:0]     m_tkeep;
    logic              m_tlast;
    logic [UW-1:0]     m_tuser;
    logic [IW-1:0]     m_tid;
    logic              busy;
    logic [IW-1:0]     grant_idx;

    axi_stream_rr_arbiter #(
        .num_inputs (N),
        .byte_width (BW),
        .user_width (UW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .s_tuser   (s_tuser),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .m_tid     (m_tid),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    typedef struct {
        logic [IW-1:0] tid;
        logic [DW-1:0] data;
        logic [BW-1:0] keep;
        logic          last;
        logic [UW-1:0] user;
    } exp_t;

    typedef struct {
        logic [N-1:0]  req;
        logic          rdy;
        logic          exp_mvalid;
        logic [IW-1:0] exp_tid;
        logic [N-1:0]  exp_sready;
        logic          exp_busy;
    } vec_t;

    int     checks   = 0;
    int     failures = 0;
    int     busy_cnt = 0;
    bit     gap_chk  = 1'b0;
    exp_t   exp_q[$];
    beat_t  src_mem [N][32];
    int     src_wr [N];
    int     src_rd [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int i, input int p, input int b);
        return {8'(i), 8'(p), 8'(b), 8'h5A};
    endfunction

    function automatic beat_t mk_beat(input int i, input int p, input int b, input int nb);
        beat_t r;
        r.data = beat_data(i, p, b);
        r.keep = (b == nb - 1) ? 4'h3 : 4'hF;
        r.last = (b == nb - 1);
        r.user = UW'(b & 1);
        return r;
    endfunction

    function automatic exp_t mk_exp(input int i, input int p, input int b, input int nb);
        exp_t  e;
        beat_t bt;
        bt     = mk_beat(i, p, b, nb);
        e.tid  = IW'(i);
        e.data = bt.data;
        e.keep = bt.keep;
        e.last = bt.last;
        e.user = bt.user;
        return e;
    endfunction

    // Queue a packet at source i; optionally push its beats to the scoreboard.
    task automatic add_pkt(input int i, input int p, input int nb, input bit push);
        for (int b = 0; b < nb; b++) begin
            src_mem[i][src_wr[i]] = mk_beat(i, p, b, nb);
            src_wr[i]++;
            if (push) exp_q.push_back(mk_exp(i, p, b, nb));
        end
    endtask

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                s_tvalid[i]            = 1'b1;
                s_tdata[i*DW +: DW]    = src_mem[i][src_rd[i]].data;
                s_tkeep[i*BW +: BW]    = src_mem[i][src_rd[i]].keep;
                s_tlast[i]             = src_mem[i][src_rd[i]].last;
                s_tuser[i*UW +: UW]    = src_mem[i][src_rd[i]].user;
            end else begin
                s_tvalid[i]            = 1'b0;
                s_tdata[i*DW +: DW]    = '0;
                s_tkeep[i*BW +: BW]    = '0;
                s_tlast[i]             = 1'b0;
                s_tuser[i*UW +: UW]    = '0;
            end
        end
    endtask

    // One clock: monitor/scoreboard on the falling edge, source advance after the rising edge.
    task automatic tick();
        logic [N-1:0] hs_s;
        logic [N-1:0] exp_sr;
        exp_t         e;
        @(negedge clk);
        if (busy) busy_cnt++;
        if (gap_chk) begin
            chk("gap_mvalid", 64'(m_tvalid), 64'd0);
            chk("gap_busy",   64'(busy),     64'd0);
        end
        gap_chk = 1'b0;
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat tid=%0d data=%0h expected=no beat", m_tid, m_tdata);
            end else begin
                e      = exp_q.pop_front();
                exp_sr = '0;
                exp_sr[e.tid] = 1'b1;
                chk("sb_tid",    64'(m_tid),    64'(e.tid));
                chk("sb_data",   64'(m_tdata),  64'(e.data));
                chk("sb_keep",   64'(m_tkeep),  64'(e.keep));
                chk("sb_last",   64'(m_tlast),  64'(e.last));
                chk("sb_user",   64'(m_tuser),  64'(e.user));
                chk("sb_sready", 64'(s_tready), 64'(exp_sr));
            end
            if (m_tlast) gap_chk = 1'b1;
        end
        hs_s = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_s[i]) src_rd[i]++;
        end
        drive_sources();
    endtask

    task automatic run_until_empty(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        tick();
        tick();
    endtask

    task automatic reset_dut();
        resetn   = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        drive_sources();
        exp_q.delete();
        gap_chk = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [8];
        vecs[0] = '{req: 4'b0000, rdy: 1'b1, exp_mvalid: 1'b0, exp_tid: 2'd0, exp_sready: 4'b0000, exp_busy: 1'b0};
        vecs[1] = '{req: 4'b0001, rdy: 1'b1, exp_mvalid: 1'b1, exp_tid: 2'd0, exp_sready: 4'b0001, exp_busy: 1'b1};
        vecs[2] = '{req: 4'b1000, rdy: 1'b1, exp_mvalid: 1'b1, exp_tid: 2'd3, exp_sready: 4'b1000, exp_busy: 1'b1};
        vecs[3] = '{req: 4'b0110, rdy: 1'b1, exp_mvalid: 1'b1, exp_tid: 2'd1, exp_sready: 4'b0010, exp_busy: 1'b1};
        vecs[4] = '{req: 4'b0110, rdy: 1'b0, exp_mvalid: 1'b1, exp_tid: 2'd1, exp_sready: 4'b0000, exp_busy: 1'b1};
        vecs[5] = '{req: 4'b1100, rdy: 1'b1, exp_mvalid: 1'b1, exp_tid: 2'd2, exp_sready: 4'b0100, exp_busy: 1'b1};
        vecs[6] = '{req: 4'b1111, rdy: 1'b1, exp_mvalid: 1'b1, exp_tid: 2'd0, exp_sready: 4'b0001, exp_busy: 1'b1};
        vecs[7] = '{req: 4'b1010, rdy: 1'b0, exp_mvalid: 1'b1, exp_tid: 2'd1, exp_sready: 4'b0000, exp_busy: 1'b1};

        // Reset state with every input requesting.
        resetn   = 1'b0;
        m_tready = 1'b1;
        s_tvalid = '1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        #12;
        chk("rst_mvalid",    64'(m_tvalid),  64'd0);
        chk("rst_sready",    64'(s_tready),  64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd3);

        // Table: first grant after reset for a static request pattern.
        for (int v = 0; v < 8; v++) begin
            reset_dut();
            for (int i = 0; i < N; i++) begin
                s_tdata[i*DW +: DW] = beat_data(i, 8'hEE, 0);
            end
            s_tvalid = vecs[v].req;
            s_tlast  = '0;
            m_tready = vecs[v].rdy;
            @(posedge clk);
            #1;
            @(negedge clk);
            chk($sformatf("vec%0d_mvalid", v), 64'(m_tvalid), 64'(vecs[v].exp_mvalid));
            chk($sformatf("vec%0d_sready", v), 64'(s_tready), 64'(vecs[v].exp_sready));
            chk($sformatf("vec%0d_busy", v),   64'(busy),     64'(vecs[v].exp_busy));
            if (vecs[v].exp_mvalid) begin
                chk($sformatf("vec%0d_tid", v),  64'(m_tid),   64'(vecs[v].exp_tid));
                chk($sformatf("vec%0d_data", v), 64'(m_tdata), 64'(beat_data(int'(vecs[v].exp_tid), 8'hEE, 0)));
            end
        end

        // All four inputs with 2-beat packets: order 0,0,1,1,2,2,3,3 with idle gaps.
        reset_dut();
        for (int i = 0; i < N; i++) add_pkt(i, 8'h10 + i, 2, 1'b1);
        drive_sources();
        run_until_empty("drain_all4", 100);

        // Only input 2 with a 3-beat packet.
        reset_dut();
        add_pkt(2, 8'h20, 3, 1'b1);
        drive_sources();
        tick();
        chk("solo2_busy",  64'(busy),      64'd1);
        chk("solo2_grant", 64'(grant_idx), 64'd2);
        chk("solo2_tid",   64'(m_tid),     64'd2);
        run_until_empty("drain_solo2", 50);
        chk("solo2_idle_busy", 64'(busy), 64'd0);

        // Input 1 holds a 4-beat grant while input 0 keeps requesting; then input 2 or wrap to 0.
        for (int v = 0; v < 2; v++) begin
            reset_dut();
            add_pkt(0, 8'h30 + v, 1, 1'b1);
            add_pkt(1, 8'h32 + v, 4, 1'b1);
            if (v == 1) add_pkt(2, 8'h34, 1, 1'b1);
            add_pkt(0, 8'h36 + v, 1, 1'b1);
            drive_sources();
            run_until_empty($sformatf("drain_hold%0d", v), 100);
        end

        // m_tready low for 5 cycles mid-packet: output must hold beat 1 of input 1.
        reset_dut();
        add_pkt(1, 8'h40, 3, 1'b1);
        drive_sources();
        tick();
        tick();
        m_tready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_mvalid", 64'(m_tvalid), 64'd1);
            chk("stall_data",   64'(m_tdata),  64'(beat_data(1, 8'h40, 1)));
            chk("stall_last",   64'(m_tlast),  64'd0);
            chk("stall_tid",    64'(m_tid),    64'd1);
            chk("stall_sready", 64'(s_tready), 64'd0);
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        run_until_empty("drain_stall", 50);

        // Asynchronous reset pulse during a 4-beat packet from input 3.
        reset_dut();
        add_pkt(3, 8'h50, 4, 1'b0);
        exp_q.push_back(mk_exp(3, 8'h50, 0, 4));
        drive_sources();
        tick();
        tick();
        chk("prerst_mvalid", 64'(m_tvalid), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_mvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_sready", 64'(s_tready), 64'd0);
        chk("midrst_busy",   64'(busy),     64'd0);
        src_rd[3] = src_wr[3];
        add_pkt(0, 8'h51, 1, 1'b1);
        add_pkt(3, 8'h52, 1, 1'b1);
        drive_sources();
        @(posedge clk);
        #3;
        resetn = 1'b1;
        run_until_empty("drain_rst", 50);

        // Single-beat packets on inputs 0 and 1: one busy cycle each.
        reset_dut();
        busy_cnt = 0;
        add_pkt(0, 8'h60, 1, 1'b1);
        add_pkt(1, 8'h61, 1, 1'b1);
        drive_sources();
        run_until_empty("drain_single", 50);
        chk("single_busy_cycles", 64'(busy_cnt), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
